branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch resolution stage for the MIPS pipeline, succeeding the purely combinational branch-compare ALU. It evaluates all conditional branches (beq, bne, bgtz, blez, bgez, bltz) with correct two's-complement signed compares and computes the taken target. It checks the outcome against the fetch-stage prediction and emits a registered redirect/mispredict pulse. It also owns a direct-mapped branch history table (BHT) of saturating counters, read combinationally by fetch and updated on resolution, plus branch and mispredict statistics counters.

## Interface
Parameters:
- WIDTH, 32, datapath/PC width
- BHT_DEPTH, 16, BHT entries; power of two, at least 2
- CTR_BITS, 2, saturating counter width
- STAT_BITS, 16, statistics counter width

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; one clock domain, asynchronous active-high reset
- In_Valid  in  1  instruction presented this cycle
- Flush  in  1  kill the instruction presented this cycle
- Opcode  in  6  instruction [31:26]
- Rt_Field  in  5  instruction [20:16]; selects the REGIMM branch
- A  in  WIDTH  rs value (forwarded)
- B  in  WIDTH  rt value (forwarded)
- PC  in  WIDTH  address of the branch
- Offset  in  WIDTH  sign-extended imm16, in words
- Pred_In  in  1  prediction fetch used for this branch
- Fetch_PC  in  WIDTH  fetch address for lookup
- Pred_Taken  out  1  combinational prediction for Fetch_PC
- Out_Valid  out  1  resolved-branch pulse
- Taken  out  1  resolved direction
- Target  out  WIDTH  PC+4+(Offset<<2)
- Mispredict  out  1  Taken != Pred_In; valid with Out_Valid
- Redirect_PC  out  WIDTH  correct next PC: Target if Taken, else PC+4
- Branch_Count  out  STAT_BITS  resolved branches
- Mispredict_Count  out  STAT_BITS  mispredicts

## Operation
- Branch decode, otherwise no action:
  - 000100 beq: A==B
  - 000101 bne: A!=B
  - 000111 bgtz: $signed(A)>0
  - 000110 blez: $signed(A)<=0
  - 000001 with Rt_Field 00001, bgez: $signed(A)>=0
  - 000001 with Rt_Field 00000, bltz: $signed(A)<0
  - 000001 with any other Rt_Field: not a branch
- Accept condition: In_Valid & !Flush & is_branch. Only an accepted branch produces Out_Valid, updates the BHT and increments the counters.
- Arithmetic: Target and PC+4 are modulo 2^WIDTH. Offset<<2 drops the top two bits.
- BHT index: PC[IDX+1:2], where IDX = log2(BHT_DEPTH). Fetch uses the same bits of Fetch_PC.
- Prediction: Pred_Taken = counter[CTR_BITS-1] at the Fetch_PC index.
- Counter update on accept: Taken increments, saturating at all-ones. Not-taken decrements, saturating at 0.
- Branch_Count increments on every accept. Mispredict_Count increments on every accept with a mispredict. Both wrap at 2^STAT_BITS.
- Reset values:
  - Out_Valid, Taken, Mispredict = 0; Target, Redirect_PC = 0
  - both statistics counters = 0
  - every BHT entry = 01..1 (weakly not-taken, value 2^(CTR_BITS-1)-1)
  - Pred_Taken therefore reads 0
- Reset mid-operation clears a pending Out_Valid immediately (asynchronous). No redirect is issued for the pending branch.

## Timing
- Latency 1. Inputs are sampled at edge N. Out_Valid, Taken, Target, Mispredict and Redirect_PC are registered and valid after edge N, for exactly one cycle.
- Back-to-back branches on consecutive cycles are supported; there is no stall.
- Data outputs hold their last value when Out_Valid=0.
- BHT and statistics counters update at the same edge N.
- Pred_Taken is combinational from Fetch_PC and the table contents.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value. The new value is visible the cycle after the edge.
- Flush and In_Valid together: the input is dropped, with no state change.
- Flush has no effect on an already-registered Out_Valid.

## Test plan
- Reset, then BHT sweep: read every index via Fetch_PC -> Pred_Taken=0 everywhere. Counters read 0.
- beq, A=B=0x5, PC=0x100, Offset=0x3, Pred_In=0 -> next cycle: Out_Valid=1, Taken=1, Target=0x110, Redirect_PC=0x110, Mispredict=1, Mispredict_Count=1.
- Signed compares with A=0xFFFFFFFF:
  - bgtz -> Taken=0
  - bltz (Rt_Field 0) -> Taken=1
  - bgez (Rt_Field 1) -> Taken=0
  - blez -> Taken=1
  - with A=0, bgez and blez -> Taken=1
- Saturation on one PC: 4 taken branches -> counter 11, Pred_Taken=1. A 5th taken branch stays at 11. Two not-taken branches -> 01, Pred_Taken=0.
- Flush and non-branch:
  - beq with Flush=1 -> no Out_Valid, BHT and counters unchanged
  - opcode 001000 -> ignored
  - opcode 000001 with Rt_Field 00010 -> ignored
- Wrap and collision:
  - PC=0xFFFFFFFC, not-taken -> Redirect_PC=0x0
  - Fetch_PC aliasing the updating index in the same cycle -> old prediction returned, new one visible next cycle
  - Branch_Count preloaded by 65535 accepts, then one more accept -> reads 0

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates MIPS conditional branches, registers the
// redirect/mispredict result, and owns the branch history table and branch statistics.
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CTR_BITS  = 2,
  parameter int STAT_BITS = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 In_Valid,
  input  logic                 Flush,
  input  logic [5:0]           Opcode,
  input  logic [4:0]           Rt_Field,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     PC,
  input  logic [WIDTH-1:0]     Offset,
  input  logic                 Pred_In,
  input  logic [WIDTH-1:0]     Fetch_PC,
  output logic                 Pred_Taken,
  output logic                 Out_Valid,
  output logic                 Taken,
  output logic [WIDTH-1:0]     Target,
  output logic                 Mispredict,
  output logic [WIDTH-1:0]     Redirect_PC,
  output logic [STAT_BITS-1:0] Branch_Count,
  output logic [STAT_BITS-1:0] Mispredict_Count
);

  localparam int IDX = $clog2(BHT_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

  logic                 w_is_branch;
  logic                 w_cond;
  logic                 w_a_neg;
  logic                 w_a_zero;
  logic                 w_accept;
  logic                 w_mispredict;
  logic [WIDTH-1:0]     w_pc_plus4;
  logic [WIDTH-1:0]     w_target;
  logic [IDX-1:0]       w_upd_idx;
  logic [IDX-1:0]       w_fetch_idx;
  logic [CTR_BITS-1:0]  w_ctr_cur;
  logic [CTR_BITS-1:0]  w_ctr_next;
  logic                 w_unused_bits;

  logic                 r_out_valid;
  logic                 r_taken;
  logic                 r_mispredict;
  logic [WIDTH-1:0]     r_target;
  logic [WIDTH-1:0]     r_redirect_pc;
  logic [STAT_BITS-1:0] r_branch_count;
  logic [STAT_BITS-1:0] r_mispredict_count;
  logic [CTR_BITS-1:0]  r_bht [BHT_DEPTH];

  // Sign and zero flags cover every signed compare against zero.
  assign w_a_neg  = A[WIDTH-1];
  assign w_a_zero = (A == '0);

  always_comb begin
    w_is_branch = 1'b0;
    w_cond      = 1'b0;
    case (Opcode)
      6'b000100: begin w_is_branch = 1'b1; w_cond = (A == B);               end
      6'b000101: begin w_is_branch = 1'b1; w_cond = (A != B);               end
      6'b000111: begin w_is_branch = 1'b1; w_cond = !w_a_neg && !w_a_zero; end
      6'b000110: begin w_is_branch = 1'b1; w_cond = w_a_neg || w_a_zero;   end
      6'b000001: begin
        case (Rt_Field)
          5'b00001: begin w_is_branch = 1'b1; w_cond = !w_a_neg; end
          5'b00000: begin w_is_branch = 1'b1; w_cond = w_a_neg;  end
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_accept     = In_Valid && !Flush && w_is_branch;
  assign w_mispredict = (w_cond != Pred_In);
  assign w_pc_plus4   = PC + WIDTH'(4);
  assign w_target     = w_pc_plus4 + {Offset[WIDTH-3:0], 2'b00};

  assign w_upd_idx   = PC[IDX+1:2];
  assign w_fetch_idx = Fetch_PC[IDX+1:2];
  assign w_ctr_cur   = r_bht[w_upd_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (w_cond) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + CTR_BITS'(1);
    end else begin
      if (w_ctr_cur != '0)      w_ctr_next = w_ctr_cur - CTR_BITS'(1);
    end
  end

  // Only the index bits of Fetch_PC and the low bits of Offset matter.
  assign w_unused_bits = ^{Fetch_PC, Offset[WIDTH-1:WIDTH-2]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out_valid   <= 1'b0;
      r_taken       <= 1'b0;
      r_mispredict  <= 1'b0;
      r_target      <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_taken       <= w_cond;
        r_mispredict  <= w_mispredict;
        r_target      <= w_target;
        r_redirect_pc <= w_cond ? w_target : w_pc_plus4;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_accept) begin
      r_branch_count <= r_branch_count + STAT_BITS'(1);
      if (w_mispredict) r_mispredict_count <= r_mispredict_count + STAT_BITS'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CTR_INIT;
    end else if (w_accept) begin
      r_bht[w_upd_idx] <= w_ctr_next;
    end
  end

  // Lookup sees the table before this edge's update.
  assign Pred_Taken       = r_bht[w_fetch_idx][CTR_BITS-1];
  assign Out_Valid        = r_out_valid;
  assign Taken            = r_taken;
  assign Mispredict       = r_mispredict;
  assign Target           = r_target;
  assign Redirect_PC      = r_redirect_pc;
  assign Branch_Count     = r_branch_count;
  assign Mispredict_Count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against an array/integer
// reference model of branch outcomes, table counters and statistics.
module tb_branch_resolve_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CMAX  = 3;
  localparam int CINIT = 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              In_Valid, Flush, Pred_In;
  logic [5:0]        Opcode;
  logic [4:0]        Rt_Field;
  logic [WIDTH-1:0]  A, B, PC, Offset, Fetch_PC;
  logic              Pred_Taken, Out_Valid, Taken, Mispredict;
  logic [WIDTH-1:0]  Target, Redirect_PC;
  logic [15:0]       Branch_Count, Mispredict_Count;

  branch_resolve_unit dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .Flush(Flush),
    .Opcode(Opcode), .Rt_Field(Rt_Field), .A(A), .B(B), .PC(PC),
    .Offset(Offset), .Pred_In(Pred_In), .Fetch_PC(Fetch_PC),
    .Pred_Taken(Pred_Taken), .Out_Valid(Out_Valid), .Taken(Taken),
    .Target(Target), .Mispredict(Mispredict), .Redirect_PC(Redirect_PC),
    .Branch_Count(Branch_Count), .Mispredict_Count(Mispredict_Count)
  );

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;

  int          m_bht [DEPTH];
  int unsigned m_bc, m_mc;
  logic        e_taken, e_mis;
  logic [31:0] e_target, e_redirect;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = CINIT;
    m_bc = 0; m_mc = 0;
    e_taken = 0; e_mis = 0; e_target = 0; e_redirect = 0;
  endfunction

  function automatic int idx_of(logic [31:0] addr);
    return int'(addr / 4) % DEPTH;
  endfunction

  // Returns -1 for non-branch, else 0/1 outcome.
  function automatic int outcome(logic [5:0] op, logic [4:0] rt, logic [31:0] a, logic [31:0] b);
    int sa;
    sa = $signed(a);
    if (op == 6'd4) return int'(a == b);
    if (op == 6'd5) return int'(a != b);
    if (op == 6'd7) return int'(sa > 0);
    if (op == 6'd6) return int'(sa <= 0);
    if (op == 6'd1 && rt == 5'd1) return int'(sa >= 0);
    if (op == 6'd1 && rt == 5'd0) return int'(sa < 0);
    return -1;
  endfunction

  task automatic branch(input logic [5:0] op, input logic [4:0] rt,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off,
                        input logic pred, input logic vld, input logic fl,
                        input logic [31:0] fpc, input bit chk);
    int  o;
    bit  acc;
    longint unsigned tgt;
    Opcode = op; Rt_Field = rt; A = a; B = b; PC = pc; Offset = off;
    Pred_In = pred; In_Valid = vld; Flush = fl; Fetch_PC = fpc;
    #1;
    if (chk) check("pred_before", Pred_Taken, m_bht[idx_of(fpc)] >= 2);
    o   = outcome(op, rt, a, b);
    acc = vld && !fl && (o >= 0);
    if (acc) begin
      tgt = (longint'(pc) + 4 + longint'(off) * 4) % (64'd1 << 32);
      e_taken    = (o == 1);
      e_mis      = (e_taken != pred);
      e_target   = tgt[31:0];
      e_redirect = e_taken ? tgt[31:0] : pc + 32'd4;
      m_bc = (m_bc + 1) % 65536;
      if (e_mis) m_mc = (m_mc + 1) % 65536;
      if (e_taken) m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == CMAX) ? CMAX : m_bht[idx_of(pc)] + 1;
      else         m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 0) ? 0 : m_bht[idx_of(pc)] - 1;
    end
    @(posedge Clk); #1;
    In_Valid = 0; Flush = 0;
    if (chk) begin
      check("out_valid", Out_Valid, acc);
      check("taken", Taken, e_taken);
      check("mispredict", Mispredict, e_mis);
      check("target", Target, e_target);
      check("redirect_pc", Redirect_PC, e_redirect);
      check("branch_count", Branch_Count, m_bc);
      check("mispredict_count", Mispredict_Count, m_mc);
      check("pred_after", Pred_Taken, m_bht[idx_of(fpc)] >= 2);
    end
  endtask

  task automatic random_branch(input bit chk);
    logic [5:0]  ops [8];
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a, b, pc;
    ops = '{6'd4, 6'd5, 6'd7, 6'd6, 6'd1, 6'd1, 6'd8, 6'd35};
    op = ops[$urandom_range(0, 7)];
    rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: a = 32'd0;
      1: a = 32'h8000_0000 | $urandom;
      default: a = $urandom;
    endcase
    b  = ($urandom_range(0, 1) == 1) ? a : $urandom;
    pc = {$urandom, 2'b00} & 32'hFFFF_FFFC;
    branch(op, rt, a, b, pc, $urandom, 1'($urandom), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1) ? pc : {$urandom, 2'b00} & 32'hFFFF_FFFC, chk);
  endtask

  initial begin
    Reset = 1; In_Valid = 0; Flush = 0; Pred_In = 0; Opcode = 0; Rt_Field = 0;
    A = 0; B = 0; PC = 0; Offset = 0; Fetch_PC = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_out_valid", Out_Valid, 0);
    check("rst_target", Target, 0);
    check("rst_redirect", Redirect_PC, 0);
    check("rst_branch_count", Branch_Count, 0);
    check("rst_mispredict_count", Mispredict_Count, 0);
    Reset = 0;
    for (int i = 0; i < DEPTH; i++) begin
      Fetch_PC = 32'(i * 4);
      #1 check("rst_bht_sweep", Pred_Taken, 0);
    end
    @(posedge Clk); #1;

    // beq equal, predicted not taken
    branch(6'd4, 5'd0, 32'h5, 32'h5, 32'h100, 32'h3, 0, 1, 0, 32'h100, 1);
    check("beq_target_abs", Target, 32'h110);
    check("beq_mis_count_abs", Mispredict_Count, 1);

    // signed compares on -1 and 0
    branch(6'd7, 5'd0, 32'hFFFF_FFFF, 0, 32'h40, 32'h1, 0, 1, 0, 0, 1);
    check("bgtz_neg", Taken, 0);
    branch(6'd1, 5'd0, 32'hFFFF_FFFF, 0, 32'h44, 32'h1, 0, 1, 0, 0, 1);
    check("bltz_neg", Taken, 1);
    branch(6'd1, 5'd1, 32'hFFFF_FFFF, 0, 32'h48, 32'h1, 0, 1, 0, 0, 1);
    check("bgez_neg", Taken, 0);
    branch(6'd6, 5'd0, 32'hFFFF_FFFF, 0, 32'h4C, 32'h1, 0, 1, 0, 0, 1);
    check("blez_neg", Taken, 1);
    branch(6'd1, 5'd1, 32'h0, 0, 32'h50, 32'h1, 0, 1, 0, 0, 1);
    check("bgez_zero", Taken, 1);
    branch(6'd6, 5'd0, 32'h0, 0, 32'h54, 32'h1, 0, 1, 0, 0, 1);
    check("blez_zero", Taken, 1);

    // saturation on one index; lookup aliases the updating index
    for (int i = 0; i < 5; i++)
      branch(6'd4, 0, 7, 7, 32'h208, 32'hFFFF_FFFE, 1, 1, 0, 32'h208, 1);
    check("sat_pred_high", Pred_Taken, 1);
    for (int i = 0; i < 2; i++)
      branch(6'd5, 0, 7, 7, 32'h208, 32'h2, 1, 1, 0, 32'h208, 1);
    check("sat_pred_low", Pred_Taken, 0);

    // flushed branch and non-branches
    branch(6'd4, 0, 1, 1, 32'h300, 32'h1, 0, 1, 1, 32'h300, 1);
    branch(6'd8, 0, 1, 1, 32'h300, 32'h1, 0, 1, 0, 32'h300, 1);
    branch(6'd1, 5'd2, 32'hFFFF_FFFF, 0, 32'h300, 32'h1, 0, 1, 0, 32'h300, 1);

    // PC wrap on a not-taken branch
    branch(6'd5, 0, 9, 9, 32'hFFFF_FFFC, 32'h10, 0, 1, 0, 32'hFFFF_FFFC, 1);
    check("wrap_redirect_abs", Redirect_PC, 32'h0);

    repeat (400) random_branch(1);

    // drive Branch_Count up to all-ones, then one more accept wraps it
    while (m_bc != 65535)
      branch(6'd4, 0, $urandom, $urandom, {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom, 1'($urandom), 1, 0, 0, 0);
    branch(6'd5, 0, 1, 2, 32'h400, 32'h4, 1, 1, 0, 32'h400, 1);
    check("branch_count_wrap", Branch_Count, 0);

    // asynchronous reset kills a pending result
    branch(6'd4, 0, 3, 3, 32'h500, 32'h8, 0, 1, 0, 32'h500, 1);
    #2 Reset = 1;
    model_reset();
    #1;
    check("async_rst_out_valid", Out_Valid, 0);
    check("async_rst_branch_count", Branch_Count, 0);
    check("async_rst_pred", Pred_Taken, 0);
    @(posedge Clk); #1;
    check("async_rst_hold", Out_Valid, 0);
    Reset = 0;
    branch(6'd6, 0, 32'h8000_0000, 0, 32'h600, 32'h2, 1, 1, 0, 32'h600, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
